// File: rtl/fb_read_arbiter_if.sv
// Port-B read bus shared between video scan-out, the secondary pixel consumer and the BRAM.
// slave = arbiter side, master = surrounding logic (video path, secondary engine, BRAM).
interface fb_read_arbiter_if #(
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned DATA_W = 12
);
  logic              vid_active_in;
  logic [ADDR_W-1:0] vid_addr_in;
  logic [DATA_W-1:0] vid_data_out;
  logic              proc_req_in;
  logic [ADDR_W-1:0] proc_addr_in;
  logic              proc_gnt_out;
  logic              proc_valid_out;
  logic [DATA_W-1:0] proc_data_out;
  logic [ADDR_W-1:0] bram_addr_out;
  logic [DATA_W-1:0] bram_dout_in;
  logic [15:0]       starve_cnt_out;

  modport slave (
    input  vid_active_in, vid_addr_in, proc_req_in, proc_addr_in, bram_dout_in,
    output vid_data_out, proc_gnt_out, proc_valid_out, proc_data_out,
           bram_addr_out, starve_cnt_out
  );

  modport master (
    output vid_active_in, vid_addr_in, proc_req_in, proc_addr_in, bram_dout_in,
    input  vid_data_out, proc_gnt_out, proc_valid_out, proc_data_out,
           bram_addr_out, starve_cnt_out
  );
endinterface

// File: rtl/fb_read_arbiter.sv
// Frame-buffer port-B read arbiter: video has absolute priority, secondary reads fill idle slots.
// Optional starvation counter enabled by defining FB_ARB_STARVE_CNT_EN.
module fb_read_arbiter #(
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned DATA_W = 12,
  parameter int unsigned RD_LAT = 2
) (
  input logic            clk_in,
  input logic            rst_in,
  fb_read_arbiter_if.slave bus
);

  logic              gnt;
  logic [1:0]        tag_q [RD_LAT+1];
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] vid_data_q;
  logic [DATA_W-1:0] proc_data_q;
  logic              proc_valid_q;

  assign gnt = bus.proc_req_in & ~bus.vid_active_in & ~rst_in;

  assign bus.proc_gnt_out   = gnt;
  assign bus.bram_addr_out  = addr_q;
  assign bus.vid_data_out   = vid_data_q;
  assign bus.proc_valid_out = proc_valid_q;
  assign bus.proc_data_out  = proc_data_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      addr_q <= '0;
    end else if (bus.vid_active_in) begin
      addr_q <= bus.vid_addr_in;
    end else if (gnt) begin
      addr_q <= bus.proc_addr_in;
    end
  end

  // tag_q[0] travels with the registered address; tag_q[RD_LAT] lines up with bram_dout_in
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int unsigned i = 0; i <= RD_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0] <= {bus.vid_active_in, gnt};
      for (int unsigned i = 1; i <= RD_LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      vid_data_q   <= '0;
      proc_valid_q <= 1'b0;
      proc_data_q  <= '0;
    end else begin
      vid_data_q   <= tag_q[RD_LAT][1] ? bus.bram_dout_in : '0;
      proc_valid_q <= tag_q[RD_LAT][0];
      if (tag_q[RD_LAT][0]) begin
        proc_data_q <= bus.bram_dout_in;
      end
    end
  end

`ifdef FB_ARB_STARVE_CNT_EN
  logic [15:0] starve_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      starve_q <= '0;
    end else if (gnt) begin
      starve_q <= '0;
    end else if (bus.proc_req_in && (starve_q != '1)) begin
      starve_q <= starve_q + 16'd1;
    end
  end

  assign bus.starve_cnt_out = starve_q;
`else
  assign bus.starve_cnt_out = '0;
`endif

endmodule

// File: doc/fb_read_arbiter.md
# fb_read_arbiter

Shares the single read port (port B) of the camera frame-buffer BRAM between the VGA scan-out path and a secondary pixel consumer, such as a tracker or colour-calibration engine that samples stored pixels. Video has absolute priority whenever the display is in its active region. The secondary requester is served only in video idle/blanking cycles, through a req/gnt handshake. A tag pipeline returns each read to its owner after the fixed BRAM latency. The block sits between the frame-buffer BRAM, the pixel mux feeding the VGA output register, and the secondary engine, all on the 65 MHz pixel clock.

## Interface
- ADDR_W, 17, frame-buffer address width (320x240 words)
- DATA_W, 12, pixel width (RGB444)
- RD_LAT, 2, BRAM read latency in cycles, from registered address to valid `bram_dout_in`; legal range 1–4
- clk_in  input  1  pixel clock (65 MHz); all logic on rising edge
- rst_in  input  1  synchronous, active-high reset
- vid_active_in  input  1  video needs a pixel this cycle
- vid_addr_in  input  ADDR_W  video read address
- vid_data_out  output  DATA_W  video pixel; 0 when the slot was not a video read
- proc_req_in  input  1  secondary read request
- proc_addr_in  input  ADDR_W  secondary read address
- proc_gnt_out  output  1  request accepted this cycle (combinational)
- proc_valid_out  output  1  one-cycle pulse, `proc_data_out` valid
- proc_data_out  output  DATA_W  secondary read data
- bram_addr_out  output  ADDR_W  registered address to BRAM port B
- bram_dout_in  input  DATA_W  BRAM port B data
- starve_cnt_out  output  16  secondary-starvation counter (see Configuration)

## Operation
- Grant rule: `proc_gnt_out = proc_req_in & ~vid_active_in & ~rst_in`.
  - Video is never stalled or stolen.
  - The secondary requester holds `proc_req_in` and `proc_addr_in` stable until granted.
- Address select, registered each cycle:
  - if `vid_active_in`, then `bram_addr_out <= vid_addr_in`;
  - else if `proc_gnt_out`, then `bram_addr_out <= proc_addr_in`;
  - else hold the previous value.
- Tag pipeline: a 2-bit {vid, proc} tag is loaded alongside the address and shifted through RD_LAT further stages. At most one bit is set per slot.
- Return, registered:
  - an emerging vid tag loads `vid_data_out <= bram_dout_in`; otherwise `vid_data_out <= 0`.
  - an emerging proc tag sets `proc_valid_out <= 1` and `proc_data_out <= bram_dout_in`; otherwise `proc_valid_out <= 0` and `proc_data_out` holds.
- Back-to-back secondary grants are allowed, one per cycle. Data returns in grant order, with no reordering.
- Idle slots (neither video nor a secondary grant) issue no read; their tag is 00.

## Timing
- Reset values:
  - `vid_data_out=0`, `proc_valid_out=0`, `proc_data_out=0`, `bram_addr_out=0`, `starve_cnt_out=0`.
  - All tag stages are 00.
- Latency: a request accepted at edge N returns its data on outputs registered at edge N+RD_LAT+1. With RD_LAT=2, an accepted address gives data 3 cycles later.
- Throughput: one read per cycle total.
- Reset mid-operation: in-flight tags are cleared. Outstanding secondary reads are discarded and never produce `proc_valid_out`. The requester reissues after reset.
- Simultaneous `vid_active_in` and `proc_req_in`: video wins and `proc_gnt_out=0`. The secondary request stays pending.
- `vid_active_in` falling with `proc_req_in` high: the grant is issued in that same cycle, with no bubble.
- Address wrap is not handled here; callers guarantee in-range addresses.

## Configuration
- `FB_ARB_STARVE_CNT_EN` defined:
  - `starve_cnt_out` increments, saturating at 16'hFFFF, on every cycle with `proc_req_in & ~proc_gnt_out`.
  - It clears to 0 on a cycle with `proc_gnt_out`.
  - It is cleared by `rst_in`.
- Undefined: `starve_cnt_out` is tied to 0 and no counter logic is synthesized.

## Test plan
- Video only: `vid_active_in=1` with `vid_addr_in` stepping 0,1,2… over BRAM preloaded with data=addr. `vid_data_out` shows 0,1,2… starting 3 cycles after the first address (RD_LAT=2). `proc_valid_out` stays 0.
- Contention: `proc_req_in=1` at addr 100 while `vid_active_in=1` for 10 cycles. Expect `proc_gnt_out=0` throughout. On the first cycle `vid_active_in=0`, `proc_gnt_out=1`. Three cycles later `proc_valid_out=1` with `proc_data_out=100`, and `vid_data_out=0` in that slot.
- Burst in blanking: secondary requests at addrs 5,6,7 on consecutive cycles with `vid_active_in=0`. Expect three consecutive `proc_valid_out` pulses carrying 5,6,7 in order.
- Reset mid-flight: grant addr 42, then assert `rst_in` one cycle later. No `proc_valid_out` ever appears, and every output reads its reset value on the cycle after the reset edge.
- Starvation (macro defined): hold `proc_req_in=1` with `vid_active_in=1` for 70000 cycles. `starve_cnt_out` saturates at 16'hFFFF, then returns to 0 on the cycle after the grant. With the macro undefined, the same stimulus gives `starve_cnt_out=0` throughout.
